// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit operands one 4-bit digit per clock,
// LSB digit first, through a single shared 4-bit adder.
// Compile option: define SUB_EN to add the 'sub' port (a - b via a + ~b + 1).
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, work_q, work_d, sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q, cout_q;
  logic            capture, last_nib;
  logic [W-1:0]    b_cap;
  logic            c_cap;
  logic [3:0]      a_nib [NIBBLES];
  logic [3:0]      b_nib [NIBBLES];
  logic [4:0]      add_res;

  // A new operation may only be accepted when no addition is running.
  assign capture  = start && (state_q != ADD);
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

`ifdef SUB_EN
  // Subtraction stores the inverted B and forces the +1 through the carry.
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  // Split captured operands into digits and build the next working register,
  // replacing only the digit currently being processed.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
      assign work_d[4*gi +: 4] = (state_q == ADD && idx_q == IW'(gi))
                                 ? add_res[3:0] : work_q[4*gi +: 4];
    end
  endgenerate

  // The one shared 4-bit ripple adder.
  assign add_res = {1'b0, a_nib[idx_q]} + {1'b0, b_nib[idx_q]} + {4'b0, carry_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = ADD;
      ADD:     if (last_nib) state_d = DONE;
      DONE:    state_d = start ? ADD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state_q == ADD);
    done = (state_q == DONE);
  end

  // Datapath: operand capture, per-digit accumulation, result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (capture) begin
      a_q     <= a;
      b_q     <= b_cap;
      carry_q <= c_cap;
      idx_q   <= '0;
      work_q  <= '0;
    end else if (state_q == ADD) begin
      work_q  <= work_d;
      carry_q <= add_res[4];
      idx_q   <= last_nib ? '0 : idx_q + 1'b1;
      // Result registers only change once the whole word is finished.
      if (last_nib) begin
        sum_q  <= work_d;
        cout_q <= add_res[4];
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: directed cases plus random operations
// compared against a whole-word arithmetic reference. Honours SUB_EN.
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Reference: full-width unsigned arithmetic, bit W is the carry-out.
  function automatic logic [W:0] ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic rc, input logic rs);
    logic [W-1:0] bb;
    logic         cc;
    bb = rs ? ~rb : rb;
    cc = rs ? 1'b1 : rc;
    return (W+1)'(ra) + (W+1)'(bb) + (W+1)'(cc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called #1 after an edge while IDLE or DONE. Returns #1 into the DONE cycle.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input bit noisy);
    logic [W:0] r;
    r     = ref_add(ta, tb_, tc, ts);
    a     = ta;
    b     = tb_;
    cin   = tc;
    sub   = ts;
    start = 1'b1;
    @(posedge clk); #1;
    if (!noisy) start = 1'b0;
    for (int k = 1; k <= NIB; k++) begin
      chk("busy_in_add", 32'(busy), 32'd1);
      chk("done_in_add", 32'(done), 32'd0);
      chk("sum_hold",    32'(sum),  32'(exp_sum));
      chk("cout_hold",   32'(cout), 32'(exp_cout));
      if (noisy) begin
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        start = (k < NIB);
      end
      @(posedge clk); #1;
    end
    exp_sum  = r[W-1:0];
    exp_cout = r[W];
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done",  32'(busy), 32'd0);
    chk("sum",        32'(sum),  32'(exp_sum));
    chk("cout",       32'(cout), 32'(exp_cout));
    $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d (exp %h/%0d)",
             ta, tb_, tc, ts, sum, cout, exp_sum, exp_cout);
  endtask

  // One cycle with no start after DONE: back to IDLE, result held.
  task automatic idle_cycle();
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle",  32'(busy), 32'd0);
    chk("sum_idle",   32'(sum),  32'(exp_sum));
    chk("cout_idle",  32'(cout), 32'(exp_cout));
  endtask

  initial begin
    logic rs;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    launch(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0); idle_cycle();
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0); idle_cycle();
    launch(16'h0B0B, 16'h0303, 1'b1, 1'b0, 1'b1); idle_cycle();
    chk("noisy_sum", 32'(sum), 32'h0E0F);
    launch(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0);
    launch(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0); // back-to-back
    chk("b2b_sum", 32'(sum), 32'h2345);
    idle_cycle();
`ifdef SUB_EN
    launch(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0); idle_cycle();
    chk("sub_neg", 32'(sum), 32'hFFFE);
    launch(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0); idle_cycle();
    chk("sub_pos", 32'({cout, sum}), 32'h1_0002);
`endif

    // Random operations, some back-to-back, some with noisy inputs while busy.
    for (int n = 0; n < 24; n++) begin
      rs = 1'b0;
`ifdef SUB_EN
      rs = 1'($urandom);
`endif
      launch(W'($urandom), W'($urandom), 1'($urandom), rs, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();
    // Leave a non-zero result in place so the reset clearing is observable.
    launch(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0); idle_cycle();

    // Reset during the second ADD cycle aborts the operation.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp_sum = '0; exp_cout = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NIB + 2; k++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    launch(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0); idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
